sync_fifo_flags: RTL
====================

# sync_fifo_flags

Single-clock, parametrised FIFO with an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It is the on-chip buffer for paths where producer and consumer share one clock. It keeps the write/read port semantics of the dual-clock FIFO: `winc`/`wfull` on the write side, `rinc`/`rempty` on the read side. Binary pointers replace Gray-coded pointers and synchronisers, so there are no cross-domain flags.

## Interface
- `DSIZE`, 8, data width in bits
- `ASIZE`, 4, address width; depth `DEPTH = 2**ASIZE`
- `AFULL_TH`, `DEPTH-2`, almost-full threshold; legal range 1..DEPTH
- `AEMPTY_TH`, 2, almost-empty threshold; legal range 0..DEPTH-1
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `clr`  in  1  synchronous flush
- `wdata`  in  DSIZE  write data
- `winc`  in  1  write request
- `rinc`  in  1  read request
- `rdata`  out  DSIZE  read data
- `wfull`  out  1  FIFO holds DEPTH words
- `rempty`  out  1  FIFO holds 0 words
- `walmost_full`  out  1  count >= AFULL_TH
- `ralmost_empty`  out  1  count <= AEMPTY_TH
- `count`  out  ASIZE+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a write was attempted while full
- `underflow`  out  1  sticky: a read was attempted while empty

## Operation
- Pointers `wptr`/`rptr` are ASIZE+1-bit binary and wrap modulo 2·DEPTH. The memory address is the low ASIZE bits.
- Write acceptance: `wen = winc & ~wfull`.
- Read acceptance: `ren = rinc & ~rempty`.
- Acceptance is judged on the registered state only. When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.
- Count update:
  - `count` increments on wen only.
  - `count` decrements on ren only.
  - `count` is unchanged on both or neither.
  - `count` never leaves 0..DEPTH.
- `wfull = (count == DEPTH)` and `rempty = (count == 0)`. Both flags, and both thresholds, are decoded from the registered `count`. No input reaches an output combinationally.
- Error flags:
  - `winc & wfull` sets `overflow`.
  - `rinc & rempty` sets `underflow`.
  - Both flags hold until `clr` or `rst`.
  - A rejected access changes no pointer, no memory word and no count.
- `clr` has priority over `winc` and `rinc` in the same cycle. On `clr`:
  - pointers, `count`, `overflow` and `underflow` go to 0;
  - memory contents are untouched;
  - `rdata` is untouched in standard mode.
- `rst` forces these values: `rdata`=0, `wfull`=0, `rempty`=1, `walmost_full`=0, `ralmost_empty`=1, `count`=0, `overflow`=0, `underflow`=0. Memory is not reset.
- Asserting `rst` mid-operation discards all contents. The first accepted write after `rst` releases lands at address 0.

## Timing
- A write accepted at edge N is visible in `count`, `rempty` and `walmost_full` after edge N.
- Standard mode:
  - `rdata` is registered; it loads `mem[rptr]` on an accepted read.
  - Read latency is 1 cycle: data is valid after the edge that accepts the read.
  - `rdata` holds its value when no read is accepted.
- Minimum write→read turnaround:
  - write at edge N;
  - `rempty` low after edge N;
  - read accepted at edge N+1;
  - data on `rdata` after edge N+1.
- At full with `winc & rinc`: the read completes, the write is rejected, `overflow` rises after that edge, and `count` becomes DEPTH-1.
- Throughput: one write and one read per cycle, sustained, whenever 0 < count < DEPTH.

## Configuration
- Macro `SYNC_FIFO_FWFT_EN`.
- Defined (first-word-fall-through):
  - `rdata = mem[rptr]`, read asynchronously from the registered read pointer.
  - The head word is presented whenever `rempty`=0.
  - `rinc` acknowledges the head; the next word appears after that edge.
  - A word written at edge N is on `rdata` after edge N.
  - `rdata` is undefined while `rempty`=1.
  - The `rst` value of `rdata` does not apply.
- Undefined: standard registered-read behaviour, as described under Timing.
- Flags, count and error behaviour are identical in both modes.

## Structure
- Package `sync_fifo_pkg` holds:
  - the `DEPTH` and count-width derivations;
  - default values for `DSIZE`, `ASIZE` and the thresholds;
  - a parameter-range check used at elaboration.
  The check fails the build when a threshold is outside its legal range.
- One sub-module, `sync_fifo_mem`: DEPTH×DSIZE dual-port array with synchronous write (`wen`, `waddr`) and asynchronous read (`raddr`). The output register for standard mode stays in the top level.

## Test plan
- Reset with `rst`=1 mid-stream, then release → `count`=0, `rempty`=1, `ralmost_empty`=1, `rdata`=0. The next write lands at address 0.
- Fill 16 words 0x00..0x0F (ASIZE=4) → `walmost_full` rises when `count` reaches 14 and `wfull` rises at 16. Drain → data comes out 0x00..0x0F in order, and `rempty` rises after the 16th read.
- Full, then `winc`=`rinc`=1 for one cycle → `count`=15, `overflow`=1, and the rejected word is absent from the output stream.
- Empty, then `winc`=`rinc`=1 with `wdata`=0xA5 → `underflow`=1, `count`=1. The next read returns 0xA5.
- Wrap-around: 40 cycles of simultaneous write/read at `count`=8 → `count` stays 8 and the output equals the input delayed by 8 words.
- `clr` with `winc`=1 at `count`=5 → next cycle `count`=0, `rempty`=1, sticky flags 0, and no write occurs.
- With `SYNC_FIFO_FWFT_EN` defined, write 0x3C at edge N → `rdata`=0x3C and `rempty`=0 after edge N, with no `rinc`.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared parameter defaults, derived widths and the threshold legality check
// for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int unsigned DSIZE_DEF     = 8;
  localparam int unsigned ASIZE_DEF     = 4;
  localparam int unsigned AEMPTY_TH_DEF = 2;

  function automatic int unsigned depth_of(input int unsigned asize);
    return 32'(1) << asize;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int unsigned cnt_width(input int unsigned asize);
    return asize + 32'(1);
  endfunction

  function automatic int unsigned afull_th_def(input int unsigned asize);
    return depth_of(asize) - 32'(2);
  endfunction

  function automatic bit thresholds_ok(input int unsigned asize,
                                       input int unsigned afull_th,
                                       input int unsigned aempty_th);
    return (afull_th >= 32'(1)) && (afull_th <= depth_of(asize)) &&
           (aempty_th <= depth_of(asize) - 32'(1));
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE dual-port storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = DSIZE_DEF,
  parameter int unsigned ASIZE     = ASIZE_DEF,
  parameter int unsigned AFULL_TH  = afull_th_def(ASIZE),
  parameter int unsigned AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = depth_of(ASIZE);
  localparam int unsigned CW    = cnt_width(ASIZE);

  if (!thresholds_ok(ASIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_threshold
    $error("sync_fifo_flags: AFULL_TH or AEMPTY_TH outside legal range");
  end

  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;
  logic [CW-1:0]    wptr_nxt;
  logic [CW-1:0]    rptr_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;
  logic             wen;
  logic             ren;
  logic             mem_wen;
  logic [DSIZE-1:0] mem_rdata;

  // Acceptance looks only at registered flags, never at the opposite port.
  assign wen     = winc & ~wfull;
  assign ren     = rinc & ~rempty;
  assign mem_wen = wen & ~clr;

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .wen   (mem_wen),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  // Next pointer/count/error state; flush overrides both ports.
  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    cnt_nxt  = count;
    ovf_nxt  = overflow | (winc & wfull);
    udf_nxt  = underflow | (rinc & rempty);
    if (clr) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
      cnt_nxt  = '0;
      ovf_nxt  = 1'b0;
      udf_nxt  = 1'b0;
    end else begin
      if (wen) wptr_nxt = wptr + CW'(1);
      if (ren) rptr_nxt = rptr + CW'(1);
      case ({wen, ren})
        2'b10:   cnt_nxt = count + CW'(1);
        2'b01:   cnt_nxt = count - CW'(1);
        default: cnt_nxt = count;
      endcase
    end
  end

  // Flags are registered from the next count so they always match count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      count         <= cnt_nxt;
      overflow      <= ovf_nxt;
      underflow     <= udf_nxt;
      wfull         <= (cnt_nxt == CW'(DEPTH));
      rempty        <= (cnt_nxt == '0);
      walmost_full  <= (cnt_nxt >= CW'(AFULL_TH));
      ralmost_empty <= (cnt_nxt <= CW'(AEMPTY_TH));
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem_rdata;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (ren & ~clr) begin
      rdata <= mem_rdata;
    end
  end
`endif

endmodule
